// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Define RAM_ARBITER_FIXED_PRIO_EN to make port 0 always win contention.
module ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_0,
  input  logic                  we_0,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] din_0,
  output logic                  gnt_0,
  output logic                  rvalid_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  input  logic                  req_1,
  input  logic                  we_1,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] din_1,
  output logic                  gnt_1,
  output logic                  rvalid_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
  } cmd_t;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  logic win_0;
  logic win_1;
  logic any_gnt;
  cmd_t sel;
  cmd_t cmd_q;
  logic en_q;
  tag_t tag_1;
  tag_t tag_2;

`ifdef RAM_ARBITER_FIXED_PRIO_EN
  assign win_0 = req_0;
  assign win_1 = req_1 & ~req_0;
`else
  logic last_gnt;

  // On contention the port that was not served last goes first.
  assign win_0 = req_0 & (~req_1 | last_gnt);
  assign win_1 = req_1 & (~req_0 | ~last_gnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (gnt_1) begin
      last_gnt <= 1'b1;
    end else if (gnt_0) begin
      last_gnt <= 1'b0;
    end
  end
`endif

  assign gnt_0   = win_0 & ~rst;
  assign gnt_1   = win_1 & ~rst;
  assign any_gnt = gnt_0 | gnt_1;

  always_comb begin
    sel = '{we: we_0, addr: addr_0, din: din_0};
    unique case (1'b1)
      gnt_1:   sel = '{we: we_1, addr: addr_1, din: din_1};
      default: ;
    endcase
  end

  // Address and data hold when idle; only enables drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      cmd_q <= '0;
      tag_1 <= '0;
      tag_2 <= '0;
    end else begin
      en_q     <= any_gnt;
      cmd_q.we <= any_gnt & sel.we;
      if (any_gnt) begin
        cmd_q.addr <= sel.addr;
        cmd_q.din  <= sel.din;
      end
      tag_1 <= '{valid: any_gnt & ~sel.we, port: gnt_1};
      tag_2 <= tag_1;
    end
  end

  assign ram_en   = en_q & ~rst;
  assign ram_we   = cmd_q.we & ~rst;
  assign ram_addr = rst ? '0 : cmd_q.addr;
  assign ram_din  = rst ? '0 : cmd_q.din;

  assign rvalid_0 = tag_2.valid & ~tag_2.port & ~rst;
  assign rvalid_1 = tag_2.valid & tag_2.port & ~rst;
  assign rdata_0  = rvalid_0 ? ram_dout : '0;
  assign rdata_1  = rvalid_1 ? ram_dout : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM.
// Expected values are hand-derived per cycle in each scenario task.
module tb_ram_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_0, we_0, gnt_0, rvalid_0;
  logic [AW-1:0] addr_0;
  logic [DW-1:0] din_0, rdata_0;
  logic          req_1, we_1, gnt_1, rvalid_1;
  logic [AW-1:0] addr_1;
  logic [DW-1:0] din_1, rdata_1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  logic          e_g0, e_g1, e_v0, e_v1;
  logic [DW-1:0] e_d0, e_d1;
  logic [AW-1:0] e_a;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else ram_dout <= mem[ram_addr];
    end
  end

  ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .din_0(din_0),
    .gnt_0(gnt_0), .rvalid_0(rvalid_0), .rdata_0(rdata_0),
    .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .din_1(din_1),
    .gnt_1(gnt_1), .rvalid_1(rvalid_1), .rdata_1(rdata_1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      next();
      req_0 = 1'b0;
      req_1 = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = '0; din_0 = '0;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = '0; din_1 = '0;
    for (int c = 0; c < 3; c++) begin
      next();
      @(negedge clk);
      n_checks++;
      if ({gnt_0, gnt_1, ram_en, ram_we} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset_ctl c%0d got g0=%b g1=%b en=%b we=%b want 0",
                 c, gnt_0, gnt_1, ram_en, ram_we);
      end
      n_checks++;
      if ({ram_addr, ram_din} !== '0) begin
        n_fail++;
        $display("FAIL reset_bus c%0d got addr=%h din=%h want 0",
                 c, ram_addr, ram_din);
      end
      n_checks++;
      if ({rvalid_0, rvalid_1, rdata_0, rdata_1} !== '0) begin
        n_fail++;
        $display("FAIL reset_rd c%0d got v0=%b v1=%b d0=%h d1=%h want 0",
                 c, rvalid_0, rvalid_1, rdata_0, rdata_1);
      end
    end
    next();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({gnt_0, gnt_1} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_gnt got g0=%b g1=%b want g0=1 g1=0",
               gnt_0, gnt_1);
    end
    idle(4);
  endtask

  task automatic test_single_port();
    for (int c = 0; c < 22; c++) begin
      next();
      req_0  = (c < 20);
      we_0   = (c < 10);
      addr_0 = AW'((c < 10) ? c : c - 10);
      din_0  = DW'(c * 5);
      @(negedge clk);
      e_g0 = (c < 20);
      e_v0 = (c >= 12);
      e_d0 = e_v0 ? DW'((c - 12) * 5) : '0;
      n_checks++;
      if ({gnt_0, gnt_1} !== {e_g0, 1'b0}) begin
        n_fail++;
        $display("FAIL single_gnt c%0d got g0=%b g1=%b want g0=%b g1=0",
                 c, gnt_0, gnt_1, e_g0);
      end
      n_checks++;
      if ({rvalid_0, rvalid_1, rdata_0} !== {e_v0, 1'b0, e_d0}) begin
        n_fail++;
        $display("FAIL single_rd c%0d got v0=%b v1=%b d0=%0d want v0=%b v1=0 d0=%0d",
                 c, rvalid_0, rvalid_1, rdata_0, e_v0, e_d0);
      end
      if (c >= 1 && c <= 20) begin
        e_a = AW'((c <= 10) ? c - 1 : c - 11);
        n_checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, c <= 10, e_a}) begin
          n_fail++;
          $display("FAIL single_ram c%0d got en=%b we=%b a=%0d want en=1 we=%b a=%0d",
                   c, ram_en, ram_we, ram_addr, c <= 10, e_a);
        end
      end
      if (c == 21) begin
        n_checks++;
        if ({ram_en, ram_we, ram_addr} !== {2'b00, AW'(9)}) begin
          n_fail++;
          $display("FAIL single_hold got en=%b we=%b a=%0d want en=0 we=0 a=9",
                   ram_en, ram_we, ram_addr);
        end
      end
    end
    idle(2);
  endtask

  task automatic test_contention();
    next();
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = AW'(3);  din_0 = DW'(15);
    next();
    req_0 = 1'b0;
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = AW'(12); din_1 = DW'(144);
    idle(3);
    next();
    rst = 1'b1;
    next();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
`ifdef RAM_ARBITER_FIXED_PRIO_EN
      req_0 = (c < 4);
      req_1 = (c < 5);
`else
      req_0 = (c < 8);
      req_1 = (c < 8);
`endif
      we_0 = 1'b0; addr_0 = AW'(3);
      we_1 = 1'b0; addr_1 = AW'(12);
      @(negedge clk);
`ifdef RAM_ARBITER_FIXED_PRIO_EN
      e_g0 = (c < 4);
      e_g1 = (c == 4);
      e_v0 = (c >= 2 && c <= 5);
      e_v1 = (c == 6);
`else
      e_g0 = (c < 8) && !c[0];
      e_g1 = (c < 8) && c[0];
      e_v0 = (c >= 2) && !c[0];
      e_v1 = (c >= 3) && c[0];
`endif
      e_d0 = e_v0 ? DW'(15) : '0;
      e_d1 = e_v1 ? DW'(144) : '0;
      n_checks++;
      if ({gnt_0, gnt_1} !== {e_g0, e_g1}) begin
        n_fail++;
        $display("FAIL cont_gnt c%0d got g0=%b g1=%b want g0=%b g1=%b",
                 c, gnt_0, gnt_1, e_g0, e_g1);
      end
      n_checks++;
      if ({rvalid_0, rdata_0} !== {e_v0, e_d0}) begin
        n_fail++;
        $display("FAIL cont_rd0 c%0d got v0=%b d0=%0d want v0=%b d0=%0d",
                 c, rvalid_0, rdata_0, e_v0, e_d0);
      end
      n_checks++;
      if ({rvalid_1, rdata_1} !== {e_v1, e_d1}) begin
        n_fail++;
        $display("FAIL cont_rd1 c%0d got v1=%b d1=%0d want v1=%b d1=%0d",
                 c, rvalid_1, rdata_1, e_v1, e_d1);
      end
      next();
    end
    req_0 = 1'b0;
    req_1 = 1'b0;
    idle(2);
  endtask

  task automatic test_same_addr();
    for (int c = 0; c < 5; c++) begin
      next();
      req_1 = (c == 0); we_1 = 1'b1; addr_1 = AW'(11); din_1 = DW'(121);
      req_0 = (c == 1); we_0 = 1'b0; addr_0 = AW'(11); din_0 = '0;
      @(negedge clk);
      e_g0 = (c == 1);
      e_g1 = (c == 0);
      e_v0 = (c == 3);
      e_d0 = e_v0 ? DW'(121) : '0;
      n_checks++;
      if ({gnt_0, gnt_1} !== {e_g0, e_g1}) begin
        n_fail++;
        $display("FAIL same_gnt c%0d got g0=%b g1=%b want g0=%b g1=%b",
                 c, gnt_0, gnt_1, e_g0, e_g1);
      end
      n_checks++;
      if ({rvalid_0, rvalid_1, rdata_0} !== {e_v0, 1'b0, e_d0}) begin
        n_fail++;
        $display("FAIL same_rd c%0d got v0=%b v1=%b d0=%0d want v0=%b v1=0 d0=%0d",
                 c, rvalid_0, rvalid_1, rdata_0, e_v0, e_d0);
      end
      if (c >= 1 && c <= 3) begin
        n_checks++;
        if ({ram_en, ram_we, ram_addr} !== {c != 3, c == 1, AW'(11)}) begin
          n_fail++;
          $display("FAIL same_ram c%0d got en=%b we=%b a=%0d want en=%b we=%b a=11",
                   c, ram_en, ram_we, ram_addr, c != 3, c == 1);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (ram_din !== DW'(121)) begin
          n_fail++;
          $display("FAIL same_din got %0d want 121", ram_din);
        end
      end
    end
    idle(1);
  endtask

  task automatic test_idle_hold();
    for (int c = 0; c < 3; c++) begin
      next();
      req_0 = (c != 1); we_0 = 1'b0; addr_0 = AW'(3);
      req_1 = (c != 1); we_1 = 1'b0; addr_1 = AW'(12);
      @(negedge clk);
`ifdef RAM_ARBITER_FIXED_PRIO_EN
      e_g0 = (c != 1);
      e_g1 = 1'b0;
`else
      e_g0 = (c == 2);
      e_g1 = (c == 0);
`endif
      n_checks++;
      if ({gnt_0, gnt_1} !== {e_g0, e_g1}) begin
        n_fail++;
        $display("FAIL hold_gnt c%0d got g0=%b g1=%b want g0=%b g1=%b",
                 c, gnt_0, gnt_1, e_g0, e_g1);
      end
      if (c == 2) begin
        n_checks++;
        if ({ram_en, ram_we} !== 2'b00) begin
          n_fail++;
          $display("FAIL hold_ram got en=%b we=%b want 0", ram_en, ram_we);
        end
      end
    end
    idle(4);
  endtask

  task automatic test_reset_mid_read();
    for (int c = 0; c < 5; c++) begin
      next();
      req_1 = (c == 0); we_1 = 1'b0; addr_1 = AW'(12);
      req_0 = 1'b0;
      rst   = (c == 1);
      @(negedge clk);
      if (c == 0) begin
        n_checks++;
        if ({gnt_0, gnt_1} !== 2'b01) begin
          n_fail++;
          $display("FAIL rstrd_gnt got g0=%b g1=%b want g0=0 g1=1",
                   gnt_0, gnt_1);
        end
      end else begin
        n_checks++;
        if ({rvalid_0, rvalid_1, rdata_1} !== '0) begin
          n_fail++;
          $display("FAIL rstrd_rv c%0d got v0=%b v1=%b d1=%h want 0",
                   c, rvalid_0, rvalid_1, rdata_1);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (ram_en !== 1'b0) begin
          n_fail++;
          $display("FAIL rstrd_en got %b want 0", ram_en);
        end
      end
    end
    idle(1);
  endtask

  always @(negedge clk) begin
    if (rvalid_0 === 1'b1 && rvalid_1 === 1'b1) begin
      n_fail++;
      $display("FAIL both_rvalid got v0=1 v1=1 want at most one");
    end
  end

  initial begin
    rst = 1'b1;
    req_0 = 1'b0; we_0 = 1'b0; addr_0 = '0; din_0 = '0;
    req_1 = 1'b0; we_1 = 1'b0; addr_1 = '0; din_1 = '0;
    test_reset();
    test_single_port();
    test_contention();
    test_same_addr();
    test_idle_hold();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
